reg_file: RTL
=============

Name: reg_file

Overview:
- Parametrised multi-register storage block; successor to the single enable register.
- Holds DEPTH architectural registers of SIZE bits for the RISC datapath.
- One byte-strobed write port, two read ports with same-cycle write bypass.
- Per-register busy scoreboard, so decode can detect read-after-write hazards against in-flight writebacks.

Parameters:
- size, 16: register width in bits; must be a multiple of 8.
- depth, 8: number of registers; must be at least 2.
- addr_w, $clog2(depth): address width, derived; not overridden.
- strb_w, size/8: byte-strobe width, derived.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, all state holds.
- wr_en  in  1  writeback valid.
- wr_addr  in  addr_w  writeback register index.
- wr_data  in  size  writeback data.
- wr_strb  in  strb_w  byte lanes to write; bit i selects wr_data[8i+7:8i].
- iss_en  in  1  issue valid; marks iss_addr busy.
- iss_addr  in  addr_w  destination register being issued.
- rd_addr_a  in  addr_w  read port A index.
- rd_data_a  out  size  read port A data, combinational.
- busy_a  out  1  register rd_addr_a has a pending writeback.
- rd_addr_b  in  addr_w  read port B index.
- rd_data_b  out  size  read port B data, combinational.
- busy_b  out  1  register rd_addr_b has a pending writeback.

Behaviour:
- Reset is synchronous, active-high, and overrides en.
  - rst high at a rising clk edge clears every register to 0 and every busy bit to 0.
  - Reset mid-operation discards all pending state; on the next cycle all outputs read 0.
- Write (wr_en & en & !rst at posedge):
  - For each lane i with wr_strb[i]=1, reg[wr_addr] lane i takes wr_data lane i.
  - Lanes with wr_strb[i]=0 hold their value.
  - busy[wr_addr] clears regardless of strobe value, including all-zero strobe.
- Issue (iss_en & en & !rst at posedge): busy[iss_addr] sets to 1.
- Issue and writeback to the same address in one cycle: busy ends at 1 (new issue wins); the data write still occurs.
- Issue or writeback to an address out of range (>= depth when depth is not a power of 2): ignored, no state change.
- en low: no data or busy change, even with wr_en or iss_en high; reads stay live.
- Read ports are combinational, zero latency, and use write bypass:
  - If wr_en & en and wr_addr==rd_addr_x: rd_data_x = per-lane mux(wr_strb ? wr_data : stored).
  - busy_x = 0 unless iss_en & en & iss_addr==rd_addr_x, in which case busy_x = 1.
  - Otherwise busy_x = stored busy, and issue this cycle also forces busy_x = 1.
  - Net effect: busy_x shows the value busy will hold after the edge.
- Both read ports may address the same register and must return identical data and busy.
- Out-of-range read address: rd_data_x = 0, busy_x = 0.
- Latency: write to read-after-edge is 1 cycle; the bypass makes write data visible in the same cycle.

Optional Feature:
- Macro: REG_FILE_ZERO_REG_EN
- Defined:
  - Register 0 is hard-wired zero; writes and issues to address 0 are ignored.
  - rd_data_x = 0 and busy_x = 0 whenever rd_addr_x==0, including under bypass.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package reg_file_pkg:
  - Default size/depth constants.
  - Function for strobe merge (old, new, strb) -> merged word.
  - Constant ZERO_IDX = 0.
- One natural sub-module, reg_file_rd_port: one combinational read port with bypass and busy-forward logic, instantiated twice.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset: write 0xBEEF to r3, assert rst 1 cycle -> rd_data_a(r3)=0x0000, all busy 0.
- Strobed write: r2=0x1234, then write 0xABCD with wr_strb=2'b01 -> r2 reads 0x12CD next cycle.
- Bypass: wr_en to r5 with 0x00FF, rd_addr_a=rd_addr_b=5 in the same cycle -> both read 0x00FF before the edge.
- Scoreboard:
  - iss_en r4 -> busy_a(r4)=1 from the next cycle.
  - wr_en r4 -> busy_a=0 combinationally.
  - Simultaneous iss_en and wr_en on r4 -> busy stays 1.
- Enable hold: en=0 with wr_en to r1=0x5555 and iss_en r1 -> r1 unchanged, busy_a(r1)=0.
- With REG_FILE_ZERO_REG_EN: write 0xFFFF and issue to r0 -> rd_data_a=0, busy_a=0 on every cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Shared definitions for the reg_file block: default geometry, the
//   register-0 index, the optional hard-wired-zero switch and the byte-strobe
//   merge helper used by both the storage update and the read bypass.
//
//   Optional feature macro: REG_FILE_ZERO_REG_EN
//     defined   -> register 0 reads as zero, writes/issues to it are dropped
//     undefined -> register 0 is an ordinary register
// -----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int unsigned DEFAULT_SIZE  = 16;
  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned ZERO_IDX      = 0;

  // Widest word the merge helper handles; callers zero-extend into it and
  // truncate back to their own width.
  localparam int unsigned MAX_SIZE = 1024;
  localparam int unsigned MAX_STRB = MAX_SIZE / 8;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  // Byte-lane merge: lane i comes from new_w when strb[i] is set, otherwise
  // it keeps old_w.
  function automatic logic [MAX_SIZE-1:0] strb_merge(
    input logic [MAX_SIZE-1:0] old_w,
    input logic [MAX_SIZE-1:0] new_w,
    input logic [MAX_STRB-1:0] strb
  );
    logic [MAX_SIZE-1:0] res;
    res = old_w;
    for (int i = 0; i < int'(MAX_STRB); i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
//   One combinational read port of reg_file. Returns the stored word merged
//   with a same-cycle writeback to the same index, and a busy flag showing the
//   value the scoreboard bit will hold after the next edge.
//
//   Ports:
//     en_i        global enable (bypass/forwarding only when high)
//     wr_en_i     writeback valid
//     wr_addr_i   writeback index
//     wr_data_i   writeback data
//     wr_strb_i   writeback byte lanes
//     iss_en_i    issue valid
//     iss_addr_i  issued destination index
//     regs_i      stored register array
//     busy_i      stored busy bits
//     rd_addr_i   read index
//     rd_data_o   read data (0 when out of range)
//     busy_o      pending-writeback flag (0 when out of range)
//
//   Optional feature macro: REG_FILE_ZERO_REG_EN (via reg_file_pkg)
// -----------------------------------------------------------------------------
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter  int unsigned SIZE   = DEFAULT_SIZE,
  parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned STRB_W = SIZE / 8
) (
  input  logic              en_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [SIZE-1:0]   wr_data_i,
  input  logic [STRB_W-1:0] wr_strb_i,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic [SIZE-1:0]   regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [SIZE-1:0]   rd_data_o,
  output logic              busy_o
);

  logic            in_range;
  logic            is_zero_reg;
  logic            wr_hit;
  logic            iss_hit;
  logic [SIZE-1:0] stored_data;
  logic            stored_busy;

  // Only reachable when DEPTH is not a power of two.
  assign in_range    = (32'(rd_addr_i) < DEPTH);
  assign is_zero_reg = ZERO_REG_EN && (32'(rd_addr_i) == ZERO_IDX);

  // A hit implies the write/issue index is also in range since it equals
  // an in-range read index.
  assign wr_hit  = wr_en_i  && en_i && (wr_addr_i  == rd_addr_i);
  assign iss_hit = iss_en_i && en_i && (iss_addr_i == rd_addr_i);

  // NOTE: every output of this always_comb gets a default first, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    stored_data = '0;
    stored_busy = 1'b0;
    if (in_range) begin
      stored_data = regs_i[rd_addr_i];
      stored_busy = busy_i[rd_addr_i];
    end
  end

  always_comb begin
    rd_data_o = stored_data;
    busy_o    = stored_busy;
    if (!in_range || is_zero_reg) begin
      rd_data_o = '0;
      busy_o    = 1'b0;
    end else begin
      if (wr_hit) begin
        rd_data_o = SIZE'(strb_merge(MAX_SIZE'(stored_data),
                                     MAX_SIZE'(wr_data_i),
                                     MAX_STRB'(wr_strb_i)));
        busy_o    = 1'b0;
      end
      // Issue is applied last: a new issue wins over a completing writeback.
      if (iss_hit) busy_o = 1'b1;
    end
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   DEPTH x SIZE architectural register file with one byte-strobed write port,
//   two combinational read ports with same-cycle write bypass, and a per-
//   register busy scoreboard (set on issue, cleared on writeback) for
//   read-after-write hazard detection in decode.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset, overrides en
//     en         global enable; low holds all state, reads stay live
//     wr_en      writeback valid          wr_addr  writeback index
//     wr_data    writeback data           wr_strb  byte lanes to write
//     iss_en     issue valid              iss_addr destination being issued
//     rd_addr_a  port A index  -> rd_data_a, busy_a
//     rd_addr_b  port B index  -> rd_data_b, busy_b
//
//   Optional feature macro: REG_FILE_ZERO_REG_EN (register 0 hard-wired zero)
// -----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int unsigned SIZE   = DEFAULT_SIZE,
  parameter  int unsigned DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned STRB_W = SIZE / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [SIZE-1:0]   wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [SIZE-1:0]   rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [SIZE-1:0]   rd_data_b,
  output logic              busy_b
);

  // Elaboration-time parameter sanity.
  if ((SIZE % 8) != 0 || SIZE == 0 || SIZE > MAX_SIZE) begin : g_bad_size
    $error("reg_file: SIZE must be a non-zero multiple of 8 up to MAX_SIZE");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("reg_file: DEPTH must be at least 2");
  end

  logic [SIZE-1:0]  regs_q [DEPTH];
  logic [SIZE-1:0]  regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_ok;
  logic iss_ok;

  // Out-of-range and (optionally) register-0 targets are dropped here so the
  // state update below only ever indexes valid entries.
  assign wr_ok  = wr_en && en && (32'(wr_addr) < DEPTH) &&
                  !(ZERO_REG_EN && (32'(wr_addr) == ZERO_IDX));
  assign iss_ok = iss_en && en && (32'(iss_addr) < DEPTH) &&
                  !(ZERO_REG_EN && (32'(iss_addr) == ZERO_IDX));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[wr_addr] = SIZE'(strb_merge(MAX_SIZE'(regs_q[wr_addr]),
                                         MAX_SIZE'(wr_data),
                                         MAX_STRB'(wr_strb)));
      // Writeback completes the register even with an all-zero strobe.
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue leaves the bit set.
    if (iss_ok) busy_d[iss_addr] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples its
  // pre-edge value. The storage array is reset too: a reset must leave every
  // register readable as zero, not just the scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  reg_file_rd_port #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_rd_port_a (
    .en_i       (en),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .rd_addr_i  (rd_addr_a),
    .rd_data_o  (rd_data_a),
    .busy_o     (busy_a)
  );

  reg_file_rd_port #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_rd_port_b (
    .en_i       (en),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .regs_i     (regs_q),
    .busy_i     (busy_q),
    .rd_addr_i  (rd_addr_b),
    .rd_data_o  (rd_data_b),
    .busy_o     (busy_b)
  );

endmodule : reg_file
